// File: rtl/pipelined_memory_if.sv
// Request/response bus between the cache controller and the backing memory.
// Ports (signals):
//   req_ren / req_raddr / req_ready            : read request handshake
//   req_wen / req_waddr / req_wcacheline       : write request (always accepted)
//   rec_en / rec_ready / rec_addr / rec_cacheline : in-order read response
// Modports: master = cache controller side, slave = memory side.
interface pipelined_memory_if #(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned LINE_BYTES = 16
);
  localparam int unsigned LINE_W = 8 * LINE_BYTES;

  logic              req_ren;
  logic [ADDR_W-1:0] req_raddr;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_waddr;
  logic [LINE_W-1:0] req_wcacheline;
  logic              rec_en;
  logic              rec_ready;
  logic [ADDR_W-1:0] rec_addr;
  logic [LINE_W-1:0] rec_cacheline;

  modport master (
    output req_ren, req_raddr, req_wen, req_waddr, req_wcacheline, rec_ready,
    input  req_ready, rec_en, rec_addr, rec_cacheline
  );

  modport slave (
    input  req_ren, req_raddr, req_wen, req_waddr, req_wcacheline, rec_ready,
    output req_ready, rec_en, rec_addr, rec_cacheline
  );
endinterface

// File: rtl/pipelined_memory.sv
// Line-granular backing memory with fixed read latency, several outstanding
// reads and an in-order, back-pressurable response channel.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset (drops all in-flight reads)
//   bus  : pipelined_memory_if.slave (read/write requests, read responses)
// Array content is undefined until written; INIT_FILE is unused.
module pipelined_memory #(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned MAX_OUT    = 4,
  parameter string       INIT_FILE  = "programs/buffer_sum.hex"
) (
  input logic               clk,
  input logic               rst,
  pipelined_memory_if.slave bus
);
  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned LINE_W = 8 * LINE_BYTES;
  localparam int unsigned IDX_W  = ADDR_W - OFF_W;
  localparam int unsigned DEPTH  = 2 ** IDX_W;
  localparam int unsigned PTR_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned CNT_W  = $clog2(MAX_OUT + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] line;
  } rd_entry_t;

  // Storage array (never reset)
  logic [LINE_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  ridx_c;
  logic [IDX_W-1:0]  widx_c;
  logic [LINE_W-1:0] rd_line_c;
  logic              accept_c;
  logic              push_c;
  logic              pop_c;

  logic [LATENCY-1:0] pipe_v_q;
  rd_entry_t          pipe_q [LATENCY];

  rd_entry_t          fifo_q [MAX_OUT];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_n;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_n;
  logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_n;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_n;

  logic              ready_q, ready_n;
  logic              rec_en_q, rec_en_n;
  logic [ADDR_W-1:0] rec_addr_q;
  logic [LINE_W-1:0] rec_line_q;
  rd_entry_t         head_n;

  // Offset bits of the write address do not select anything
  logic unused_woff;
  assign unused_woff = ^bus.req_waddr[OFF_W-1:0];

  localparam string unused_init_file = INIT_FILE;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign ridx_c   = bus.req_raddr[ADDR_W-1:OFF_W];
  assign widx_c   = bus.req_waddr[ADDR_W-1:OFF_W];
  assign accept_c = bus.req_ren && ready_q;
  assign push_c   = pipe_v_q[LATENCY-1];
  assign pop_c    = rec_en_q && bus.rec_ready;

  // Read capture with same-cycle write forwarding
  assign rd_line_c = (bus.req_wen && (widx_c == ridx_c)) ? bus.req_wcacheline : mem[ridx_c];

  // Write port: committed at the edge, independent of read flow control
  always_ff @(posedge clk) begin
    if (bus.req_wen) begin
      mem[widx_c] <= bus.req_wcacheline;
    end
  end

  // Next-state for counters, pointers and the registered response head
  always_comb begin
    out_cnt_n  = out_cnt_q;
    fifo_cnt_n = fifo_cnt_q;
    wr_ptr_n   = wr_ptr_q;
    rd_ptr_n   = rd_ptr_q;
    head_n     = '{addr: rec_addr_q, line: rec_line_q};

    if (accept_c && !pop_c) begin
      out_cnt_n = out_cnt_q + CNT_W'(1);
    end else if (!accept_c && pop_c) begin
      out_cnt_n = out_cnt_q - CNT_W'(1);
    end

    if (push_c && !pop_c) begin
      fifo_cnt_n = fifo_cnt_q + CNT_W'(1);
    end else if (!push_c && pop_c) begin
      fifo_cnt_n = fifo_cnt_q - CNT_W'(1);
    end

    if (push_c) begin
      wr_ptr_n = ptr_inc(wr_ptr_q);
    end
    if (pop_c) begin
      rd_ptr_n = ptr_inc(rd_ptr_q);
    end

    // Only count-derived, so rec_ready never reaches req_ready combinationally
    ready_n  = (out_cnt_n < CNT_W'(MAX_OUT));
    rec_en_n = (fifo_cnt_n != '0);

    // If the FIFO drains to empty this edge, the entry being pushed becomes head
    if (rec_en_n) begin
      if ((fifo_cnt_q == '0) || ((fifo_cnt_q == CNT_W'(1)) && pop_c)) begin
        head_n = pipe_q[LATENCY-1];
      end else begin
        head_n = fifo_q[rd_ptr_n];
      end
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      out_cnt_q  <= '0;
      ready_q    <= 1'b1;
      rec_en_q   <= 1'b0;
      rec_addr_q <= '0;
      rec_line_q <= '0;
    end else begin
      pipe_v_q[0] <= accept_c;
      for (int i = 1; i < int'(LATENCY); i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
      end
      wr_ptr_q   <= wr_ptr_n;
      rd_ptr_q   <= rd_ptr_n;
      fifo_cnt_q <= fifo_cnt_n;
      out_cnt_q  <= out_cnt_n;
      ready_q    <= ready_n;
      rec_en_q   <= rec_en_n;
      rec_addr_q <= head_n.addr;
      rec_line_q <= head_n.line;
    end
  end

  // Payload storage; validity is tracked by the reset-cleared control above
  always_ff @(posedge clk) begin
    pipe_q[0] <= '{addr: bus.req_raddr, line: rd_line_c};
    for (int i = 1; i < int'(LATENCY); i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
    if (push_c) begin
      fifo_q[wr_ptr_q] <= pipe_q[LATENCY-1];
    end
  end

  assign bus.req_ready     = ready_q;
  assign bus.rec_en        = rec_en_q;
  assign bus.rec_addr      = rec_addr_q;
  assign bus.rec_cacheline = rec_line_q;

endmodule
